uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
Parametrised UART transmit framer, the successor to the fixed-rate transmitter.
- Adds a runtime baud divider, runtime parity and stop-bit selection, generic data width, and a valid/ready input handshake.
- Supports back-to-back frames.
- Sits between a byte-stream producer (FIFO/CPU register) and the serial pin.

Parameters:
DATA_W, 8, data bits per frame (5..9), sent LSB first
DIV_W, 16, width of baud divider configuration

Ports:
tx_clk  input  1  system clock
tx_rst_n  input  1  reset
cfg_div  input  DIV_W  clocks per bit minus 1 (0 = one bit per clock)
cfg_parity  input  2  00 none, 01 odd, 10 even, 11 none
cfg_stop2  input  1  1 = two stop bits, 0 = one
s_valid  input  1  producer has a word
s_data  input  DATA_W  word to send
s_ready  output  1  framer accepts s_data this cycle
tx_line  output  1  serial output, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset: tx_rst_n, asynchronous, active-low; clock tx_clk.
- Reset values:
  - tx_line=1, tx_busy=0, tx_done=0, s_ready=1 (after release).
  - FSM in IDLE; all counters 0.
- Outputs: all registered; tx_line is glitch-free.
- Accept: s_valid && s_ready at edge T.
  - s_data, cfg_div, cfg_parity and cfg_stop2 are captured into shadow registers at T.
  - Config changes during a frame have no effect until the next accept.
- s_ready is high in IDLE.
  - It is also high in the final clock of the last stop bit, giving back-to-back frames with zero idle cycles.
  - It is low otherwise.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or START on a back-to-back accept.
- Bit timing:
  - Every bit occupies exactly cfg_div+1 clocks, timed by the baud counter.
  - The counter reloads at each bit boundary.
  - The start bit (0) drives tx_line from T+1.
- DATA: DATA_W bits, LSB first. Bit index counter is clog2(DATA_W) wide and cleared on entry.
- PARITY: present only for modes 01/10.
  - Odd: p = ~^data, so data plus p has an odd number of ones.
  - Even: p = ^data.
- STOP: tx_line=1 for 1 or 2 bit periods.
- tx_busy: high from T+1 through the last clock of the last stop bit.
- tx_done: single-cycle pulse in the clock after the last stop bit completes.
  - On a back-to-back frame it coincides with the first start-bit clock of the next frame.
- Frame length in clocks: (cfg_div+1)*(1+DATA_W+P+S), where P ∈ {0,1} and S ∈ {1,2}.
- Divider: cfg_div=0 is legal; the counter never wraps incorrectly at max value.
- s_valid low at the end of STOP: return to IDLE with tx_line=1.
- Reset mid-frame:
  - tx_line=1 immediately (asynchronous); the frame is discarded and no tx_done pulse is produced.
  - s_ready=1 on the first clock after release.
- s_valid while busy (not last cycle): ignored; the producer holds data (AXI-style rule).

Decomposition:
- Shared package uart_pkg:
  - Parity constants PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10.
  - TX state encoding (IDLE, START, DATA, PARITY, STOP).
- Sub-module uart_baud_tick: DIV_W-bit down-counter with load/enable; outputs bit_end strobe. Reused by the future RX block.

Test Plan:
- cfg_div=0, parity 00, stop1, s_data=0xA5 -> tx_line per clock 0,1,0,1,0,0,1,0,1,1; tx_done pulse one clock after the stop bit; 10 clocks busy.
- cfg_div=3, even parity, stop2, s_data=0x07 -> each bit held 4 clocks; parity bit=1; frame 12 bits = 48 clocks busy; tx_done once.
- Odd parity, s_data=0x00 -> parity bit=1; odd parity, s_data=0x01 -> parity bit=0.
- s_valid held high with 0x11 then 0x22, cfg_div=1 -> second start bit follows the last stop clock with zero idle; s_ready high exactly one clock per frame.
- cfg_div changed 3->7 mid-frame -> current frame keeps 4-clock bits; next frame uses 8-clock bits.
- tx_rst_n asserted mid-DATA -> tx_line=1 asynchronously, no tx_done; after release, s_ready=1 and a fresh 0x5A frame is transmitted correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART TX framer and the future RX block.
//   PAR_*      : cfg_parity encodings (2'b11 behaves as none)
//   tx_state_e : transmit state machine encoding
//   parity_en  : 1 when a parity mode inserts a parity bit
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    function automatic logic parity_en(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period down-counter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val (takes priority over counting)
//   i_load_val     : clocks per bit minus 1
//   i_en           : count enable
//   o_bit_end      : high during the last clock of the current bit period
//   o_count        : current count, lets the user anticipate o_bit_end
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_bit_end,
    output logic [DIV_W-1:0] o_count
);

    logic [DIV_W-1:0] r_count;

    // Saturates at zero so an unreloaded counter never wraps to the max value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - DIV_W'(1);
        end
    end

    assign o_bit_end = i_en && (r_count == '0);
    assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmit framer with runtime divider, parity and stop bits.
//   tx_clk, tx_rst_n : clock, asynchronous active-low reset
//   cfg_div          : clocks per bit minus 1
//   cfg_parity       : 00/11 none, 01 odd, 10 even
//   cfg_stop2        : 1 = two stop bits
//   s_valid, s_data  : producer word, accepted when s_valid && s_ready
//   s_ready          : high in idle and in the final clock of the last stop bit
//   tx_line          : serial output, idle high
//   tx_busy          : frame in progress
//   tx_done          : one-cycle pulse after the last stop bit
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              tx_clk,
    input  logic              tx_rst_n,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              tx_line,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned     IdxW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

    tx_state_e         r_state;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_shift;
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_par;
    logic              r_stop2;
    logic [IdxW-1:0]   r_bit_idx;
    logic              r_stop_idx;
    logic              r_line;
    logic              r_busy;
    logic              r_done;
    logic              r_ready;

    logic              w_accept;
    logic              w_bit_end;
    logic [DIV_W-1:0]  w_count;
    logic              w_last_stop;
    logic              w_frame_end;
    logic              w_load;
    logic [DIV_W-1:0]  w_load_val;
    logic              w_parity;
    logic              w_div_zero;

    assign w_accept    = s_valid && r_ready;
    assign w_last_stop = (r_state == StStop) && (r_stop_idx == r_stop2);
    assign w_frame_end = w_last_stop && w_bit_end;
    assign w_load      = w_accept || (w_bit_end && !w_frame_end);
    assign w_load_val  = w_accept ? cfg_div : r_div;
    assign w_parity    = (r_par == PAR_ODD) ? ~^r_data : ^r_data;
    assign w_div_zero  = (r_div == '0);

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_baud (
        .i_clk      (tx_clk),
        .i_rst_n    (tx_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (r_state != StIdle),
        .o_bit_end  (w_bit_end),
        .o_count    (w_count)
    );

    // r_ready is registered, so it is raised one clock early: it must be high exactly
    // in the clock where the last stop bit ends (counter at zero).
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            r_state    <= StIdle;
            r_data     <= '0;
            r_shift    <= '0;
            r_div      <= '0;
            r_par      <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_line     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_done  <= 1'b0;
            r_ready <= 1'b0;
            if (w_accept) begin
                // Idle start or back-to-back start from the final stop clock.
                r_data  <= s_data;
                r_shift <= s_data;
                r_div   <= cfg_div;
                r_par   <= cfg_parity;
                r_stop2 <= cfg_stop2;
                r_state <= StStart;
                r_line  <= 1'b0;
                r_busy  <= 1'b1;
                r_done  <= (r_state == StStop);
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_ready <= 1'b1;
                        r_line  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    StStart: begin
                        if (w_bit_end) begin
                            r_state   <= StData;
                            r_bit_idx <= '0;
                            r_line    <= r_shift[0];
                        end
                    end
                    StData: begin
                        if (w_bit_end) begin
                            if (r_bit_idx != LastIdx) begin
                                r_bit_idx <= r_bit_idx + IdxW'(1);
                                r_shift   <= r_shift >> 1;
                                r_line    <= r_shift[1];
                            end else if (parity_en(r_par)) begin
                                r_state <= StParity;
                                r_line  <= w_parity;
                            end else begin
                                r_state    <= StStop;
                                r_stop_idx <= 1'b0;
                                r_line     <= 1'b1;
                                r_ready    <= !r_stop2 && w_div_zero;
                            end
                        end
                    end
                    StParity: begin
                        if (w_bit_end) begin
                            r_state    <= StStop;
                            r_stop_idx <= 1'b0;
                            r_line     <= 1'b1;
                            r_ready    <= !r_stop2 && w_div_zero;
                        end
                    end
                    StStop: begin
                        if (w_frame_end) begin
                            r_state <= StIdle;
                            r_line  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                        end else if (w_bit_end) begin
                            r_stop_idx <= 1'b1;
                            r_ready    <= w_div_zero;
                        end else begin
                            r_ready <= w_last_stop && (w_count == DIV_W'(1));
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_line  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_ready = r_ready;
    assign tx_line = r_line;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_framer.sv
module tb_uart_tx_framer;

    logic        tx_clk = 1'b0;
    logic        tx_rst_n = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        tx_line;
    logic        tx_busy;
    logic        tx_done;

    int n_checks = 0;
    int n_pass = 0;

    logic cap_line [256];
    logic cap_busy [256];
    logic cap_done [256];
    logic cap_ready [256];

    always #5 tx_clk = ~tx_clk;

    uart_tx_framer #(
        .DATA_W(8),
        .DIV_W (16)
    ) dut (
        .tx_clk     (tx_clk),
        .tx_rst_n   (tx_rst_n),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .tx_line    (tx_line),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    // Offers d, returns just after the accepting edge T. With keep set, s_valid stays
    // high and s_data switches to d_next for a back-to-back frame.
    task automatic start_frame(input logic [7:0] d, input logic keep, input logic [7:0] d_next);
        bit ok;
        ok = 1'b0;
        @(posedge tx_clk); #1;
        s_data = d;
        s_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge tx_clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge tx_clk); #1;
        if (keep) s_data = d_next;
        else s_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL handshake: s_ready=0 for 300 clocks, required 1");
        else n_pass++;
    endtask

    // Records outputs for n clocks after T; a further accept drops s_valid.
    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            logic acc;
            @(negedge tx_clk);
            cap_line[k] = tx_line;
            cap_busy[k] = tx_busy;
            cap_done[k] = tx_done;
            cap_ready[k] = s_ready;
            acc = s_valid && s_ready;
            @(posedge tx_clk); #1;
            if (acc) s_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({tx_line, tx_busy, tx_done} !== 3'b100)
            $display("FAIL reset_outputs: line/busy/done=%b required 100",
                     {tx_line, tx_busy, tx_done});
        else n_pass++;
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        @(negedge tx_clk);
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", s_ready);
        else n_pass++;
        n_checks++;
        if ({tx_line, tx_busy, tx_done} !== 3'b100)
            $display("FAIL idle_outputs: line/busy/done=%b required 100",
                     {tx_line, tx_busy, tx_done});
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [9:0] obs;
        logic [9:0] exp_seq;
        int busy_cnt;
        int done_cnt;
        exp_seq = 10'b1101001010;  // index 0 = first clock
        cfg_div = 16'd0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        start_frame(8'hA5, 1'b0, 8'h00);
        capture(14);
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 10; k++) obs[k] = cap_line[k];
        for (int k = 0; k < 14; k++) begin
            busy_cnt += int'(cap_busy[k]);
            done_cnt += int'(cap_done[k]);
        end
        n_checks++;
        if (obs !== exp_seq) $display("FAIL basic_line: got %b required %b", obs, exp_seq);
        else n_pass++;
        n_checks++;
        if (busy_cnt != 10) $display("FAIL basic_busy: got %0d clocks required 10", busy_cnt);
        else n_pass++;
        n_checks++;
        if (cap_done[10] !== 1'b1 || done_cnt != 1)
            $display("FAIL basic_done: done[10]=%b count=%0d required 1/1", cap_done[10], done_cnt);
        else n_pass++;
        n_checks++;
        if ({cap_line[10], cap_line[13], cap_ready[11]} !== 3'b111)
            $display("FAIL basic_idle: line/line/ready=%b required 111",
                     {cap_line[10], cap_line[13], cap_ready[11]});
        else n_pass++;
    endtask

    task automatic test_even_stop2;
        logic [11:0] exp_bits;
        int bad;
        int busy_cnt;
        int done_cnt;
        exp_bits = 12'b111000001110;
        cfg_div = 16'd3; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
        start_frame(8'h07, 1'b0, 8'h00);
        capture(56);
        bad = 0; busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 48; k++) if (cap_line[k] !== exp_bits[k / 4]) bad++;
        for (int k = 0; k < 56; k++) begin
            busy_cnt += int'(cap_busy[k]);
            done_cnt += int'(cap_done[k]);
        end
        n_checks++;
        if (bad != 0) $display("FAIL even_line: %0d wrong clocks required 0", bad);
        else n_pass++;
        n_checks++;
        if ({cap_line[36], cap_line[39]} !== 2'b11)
            $display("FAIL even_parity_bit: got %b required 11", {cap_line[36], cap_line[39]});
        else n_pass++;
        n_checks++;
        if (busy_cnt != 48) $display("FAIL even_busy: got %0d clocks required 48", busy_cnt);
        else n_pass++;
        n_checks++;
        if (cap_done[48] !== 1'b1 || done_cnt != 1)
            $display("FAIL even_done: done[48]=%b count=%0d required 1/1", cap_done[48], done_cnt);
        else n_pass++;
    endtask

    task automatic test_parity;
        int busy_cnt;
        cfg_div = 16'd0; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
        start_frame(8'h00, 1'b0, 8'h00);
        capture(13);
        n_checks++;
        if ({cap_line[9], cap_line[10], cap_done[11]} !== 3'b111)
            $display("FAIL odd_00: parity/stop/done=%b required 111",
                     {cap_line[9], cap_line[10], cap_done[11]});
        else n_pass++;
        start_frame(8'h01, 1'b0, 8'h00);
        capture(13);
        n_checks++;
        if (cap_line[9] !== 1'b0) $display("FAIL odd_01: parity got %b required 0", cap_line[9]);
        else n_pass++;
        cfg_parity = 2'b11;
        start_frame(8'h00, 1'b0, 8'h00);
        capture(13);
        busy_cnt = 0;
        for (int k = 0; k < 13; k++) busy_cnt += int'(cap_busy[k]);
        n_checks++;
        if (busy_cnt != 10 || cap_done[10] !== 1'b1)
            $display("FAIL mode11_none: busy=%0d done[10]=%b required 10/1", busy_cnt, cap_done[10]);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [19:0] exp_bits;
        int bad;
        int ready_cnt;
        int busy_cnt;
        int done_cnt;
        exp_bits = {10'b1001000100, 10'b1000100010};
        cfg_div = 16'd1; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        start_frame(8'h11, 1'b1, 8'h22);
        capture(44);
        bad = 0; ready_cnt = 0; busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (cap_line[k] !== exp_bits[k / 2]) bad++;
            ready_cnt += int'(cap_ready[k]);
        end
        for (int k = 0; k < 44; k++) begin
            busy_cnt += int'(cap_busy[k]);
            done_cnt += int'(cap_done[k]);
        end
        n_checks++;
        if (bad != 0) $display("FAIL b2b_line: %0d wrong clocks required 0", bad);
        else n_pass++;
        n_checks++;
        if (ready_cnt != 2 || cap_ready[19] !== 1'b1 || cap_ready[39] !== 1'b1)
            $display("FAIL b2b_ready: count=%0d r19=%b r39=%b required 2/1/1",
                     ready_cnt, cap_ready[19], cap_ready[39]);
        else n_pass++;
        n_checks++;
        if (busy_cnt != 40) $display("FAIL b2b_busy: got %0d clocks required 40", busy_cnt);
        else n_pass++;
        n_checks++;
        if (done_cnt != 2 || cap_done[20] !== 1'b1 || cap_done[40] !== 1'b1)
            $display("FAIL b2b_done: count=%0d d20=%b d40=%b required 2/1/1",
                     done_cnt, cap_done[20], cap_done[40]);
        else n_pass++;
    endtask

    task automatic test_div_change;
        logic [9:0] exp1;
        logic [9:0] exp2;
        int bad;
        int busy_cnt;
        exp1 = 10'b1001111000;
        exp2 = 10'b1110000110;
        cfg_div = 16'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        start_frame(8'h3C, 1'b1, 8'hC3);
        cfg_div = 16'd7;
        capture(125);
        bad = 0; busy_cnt = 0;
        for (int k = 0; k < 40; k++) if (cap_line[k] !== exp1[k / 4]) bad++;
        for (int k = 40; k < 120; k++) if (cap_line[k] !== exp2[(k - 40) / 8]) bad++;
        for (int k = 0; k < 125; k++) busy_cnt += int'(cap_busy[k]);
        n_checks++;
        if (bad != 0) $display("FAIL divchg_line: %0d wrong clocks required 0", bad);
        else n_pass++;
        n_checks++;
        if (busy_cnt != 120) $display("FAIL divchg_busy: got %0d clocks required 120", busy_cnt);
        else n_pass++;
        n_checks++;
        if ({cap_done[40], cap_done[120], cap_done[119]} !== 3'b110)
            $display("FAIL divchg_done: d40/d120/d119=%b required 110",
                     {cap_done[40], cap_done[120], cap_done[119]});
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [9:0] exp_bits;
        int bad;
        int done_cnt;
        exp_bits = 10'b1010110100;
        cfg_div = 16'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        start_frame(8'h5A, 1'b0, 8'h00);
        repeat (6) @(negedge tx_clk);
        n_checks++;
        if ({tx_line, tx_busy} !== 2'b01)
            $display("FAIL mid_pre: line/busy=%b required 01", {tx_line, tx_busy});
        else n_pass++;
        #1 tx_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_line, tx_busy, tx_done} !== 3'b100)
            $display("FAIL mid_async: line/busy/done=%b required 100",
                     {tx_line, tx_busy, tx_done});
        else n_pass++;
        @(negedge tx_clk);
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        done_cnt = 0; bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge tx_clk);
            if (k == 0) begin
                n_checks++;
                if (s_ready !== 1'b1) $display("FAIL mid_ready: got %b required 1", s_ready);
                else n_pass++;
            end
            done_cnt += int'(tx_done);
            if (tx_line !== 1'b1) bad++;
        end
        n_checks++;
        if (done_cnt != 0 || bad != 0)
            $display("FAIL mid_quiet: done=%0d low_line=%0d required 0/0", done_cnt, bad);
        else n_pass++;
        start_frame(8'h5A, 1'b0, 8'h00);
        capture(44);
        bad = 0;
        for (int k = 0; k < 40; k++) if (cap_line[k] !== exp_bits[k / 4]) bad++;
        n_checks++;
        if (bad != 0 || cap_done[40] !== 1'b1)
            $display("FAIL mid_fresh: %0d wrong clocks done[40]=%b required 0/1", bad, cap_done[40]);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_even_stop2();
        test_parity();
        test_back_to_back();
        test_div_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
